// File: rtl/pcie_us_pkg.sv
// Shared UltraScale PCIe CQ/CC definitions: request encodings, completion
// status codes, descriptor bit offsets and width-derived tuser defaults.
package pcie_us_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ      = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_CC_SEND   = 3'd4,
    ST_DROP      = 3'd5
  } state_e;

  localparam logic [3:0] REQ_MEM_RD     = 4'b0000;
  localparam logic [3:0] REQ_MEM_WR     = 4'b0001;
  localparam logic [3:0] REQ_IO_RD      = 4'b0010;
  localparam logic [3:0] REQ_IO_WR      = 4'b0011;
  localparam logic [3:0] REQ_FETCH_ADD  = 4'b0100;
  localparam logic [3:0] REQ_SWAP       = 4'b0101;
  localparam logic [3:0] REQ_CAS        = 4'b0110;
  localparam logic [3:0] REQ_MSG        = 4'b1100;
  localparam logic [3:0] REQ_MSG_VENDOR = 4'b1101;

  localparam logic [2:0] CPL_SC = 3'd0;
  localparam logic [2:0] CPL_UR = 3'd1;
  localparam logic [2:0] CPL_CA = 3'd4;

  localparam int unsigned CQ_DWCNT_LSB   = 64;
  localparam int unsigned CQ_REQTYPE_LSB = 75;
  localparam int unsigned CQ_REQID_LSB   = 80;
  localparam int unsigned CQ_TAG_LSB     = 96;
  localparam int unsigned CQ_TC_LSB      = 121;
  localparam int unsigned CQ_ATTR_LSB    = 124;
  localparam int unsigned CQ_DATA_LSB    = 128;

  localparam int unsigned CC_LOWADDR_LSB  = 0;
  localparam int unsigned CC_BYTECNT_LSB  = 16;
  localparam int unsigned CC_DWCNT_LSB    = 32;
  localparam int unsigned CC_STATUS_LSB   = 43;
  localparam int unsigned CC_REQID_LSB    = 48;
  localparam int unsigned CC_TAG_LSB      = 64;
  localparam int unsigned CC_CPLID_LSB    = 72;
  localparam int unsigned CC_CPLID_EN_BIT = 88;
  localparam int unsigned CC_TC_LSB       = 89;
  localparam int unsigned CC_ATTR_LSB     = 92;
  localparam int unsigned CC_DATA_LSB     = 96;

  function automatic int cq_user_width(input int data_width);
    return (data_width < 512) ? 85 : 183;
  endfunction

  function automatic int cc_user_width(input int data_width);
    return (data_width < 512) ? 33 : 81;
  endfunction

endpackage

// File: rtl/pcie_us_be_decode.sv
// First-DW byte-enable decode: completion byte count and offset of the lowest
// enabled byte (used for the completion lower address).
module pcie_us_be_decode
  import pcie_us_pkg::*;
(
  input  logic [3:0] first_be,
  output logic [2:0] byte_count,
  output logic [1:0] low_offset
);

  always_comb begin
    casez (first_be)
      4'b1??1:                    byte_count = 3'd4;
      4'b01?1, 4'b1?10:           byte_count = 3'd3;
      4'b0011, 4'b0110, 4'b1100:  byte_count = 3'd2;
      default:                    byte_count = 3'd1;
    endcase
  end

  always_comb begin
    if (first_be[0])      low_offset = 2'd0;
    else if (first_be[1]) low_offset = 2'd1;
    else if (first_be[2]) low_offset = 2'd2;
    else if (first_be[3]) low_offset = 2'd3;
    else                  low_offset = 2'd0;
  end

endmodule

// File: rtl/pcie_us_cq_reg_target.sv
// Single-DWORD register completer: turns 1-DW CQ memory requests into register
// strobes and answers reads (and unsupported non-posted requests) on CC.
module pcie_us_cq_reg_target
  import pcie_us_pkg::*;
#(
  parameter int AXIS_PCIE_DATA_WIDTH    = 256,
  parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
  parameter int AXIS_PCIE_CQ_USER_WIDTH = cq_user_width(AXIS_PCIE_DATA_WIDTH),
  parameter int AXIS_PCIE_CC_USER_WIDTH = cc_user_width(AXIS_PCIE_DATA_WIDTH),
  parameter int REG_ADDR_WIDTH          = 16,
  parameter int RD_TIMEOUT              = 255
) (
  input  logic                               clk,
  input  logic                               rst,

  input  logic [AXIS_PCIE_DATA_WIDTH-1:0]    s_axis_cq_tdata,
  input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    s_axis_cq_tkeep,
  input  logic                               s_axis_cq_tvalid,
  output logic                               s_axis_cq_tready,
  input  logic                               s_axis_cq_tlast,
  input  logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] s_axis_cq_tuser,

  output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_cc_tdata,
  output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_cc_tkeep,
  output logic                               m_axis_cc_tvalid,
  input  logic                               m_axis_cc_tready,
  output logic                               m_axis_cc_tlast,
  output logic [AXIS_PCIE_CC_USER_WIDTH-1:0] m_axis_cc_tuser,

  input  logic [15:0]                        completer_id,

  output logic [REG_ADDR_WIDTH-1:0]          reg_wr_addr,
  output logic [31:0]                        reg_wr_data,
  output logic [3:0]                         reg_wr_strb,
  output logic                               reg_wr_en,
  output logic [REG_ADDR_WIDTH-1:0]          reg_rd_addr,
  output logic                               reg_rd_en,
  input  logic [31:0]                        reg_rd_data,
  input  logic                               reg_rd_ack,

  output logic                               status_error_uncor
);

  if (AXIS_PCIE_DATA_WIDTH != 256 && AXIS_PCIE_DATA_WIDTH != 512) begin : g_bad_width
    $error("pcie_us_cq_reg_target: AXIS_PCIE_DATA_WIDTH must be 256 or 512");
  end

  // Address bits kept must also cover addr[6:2] for the completion lower address.
  localparam int ADDR_KEEP_W = (REG_ADDR_WIDTH > 7) ? REG_ADDR_WIDTH : 7;
  localparam int TMR_W       = ($clog2(RD_TIMEOUT + 1) > 8) ? $clog2(RD_TIMEOUT + 1) : 8;

  state_e                 state_q, state_d;
  logic                   cq_tready_q, cq_tready_d;
  logic [ADDR_KEEP_W-1:2] addr_q, addr_d;
  logic [3:0]             first_be_q, first_be_d;
  logic [15:0]            req_id_q, req_id_d;
  logic [7:0]             tag_q, tag_d;
  logic [2:0]             tc_q, tc_d;
  logic [2:0]             attr_q, attr_d;
  logic [31:0]            data_q, data_d;
  logic                   last_q, last_d;
  logic                   ur_q, ur_d;
  logic                   err_q, err_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;

  logic [10:0] req_dw_cnt;
  logic [3:0]  req_type;
  logic        req_non_posted;
  logic        cq_hs;
  logic        cc_valid;
  logic [2:0]  be_byte_count;
  logic [1:0]  be_low_offset;
  logic        unused_in;

  assign req_dw_cnt = s_axis_cq_tdata[CQ_DWCNT_LSB +: 11];
  assign req_type   = s_axis_cq_tdata[CQ_REQTYPE_LSB +: 4];
  assign req_non_posted = (req_type == REQ_MEM_RD) || (req_type == REQ_IO_RD) ||
                          (req_type == REQ_IO_WR) || (req_type == REQ_FETCH_ADD) ||
                          (req_type == REQ_SWAP) || (req_type == REQ_CAS);
  assign cq_hs    = s_axis_cq_tvalid && cq_tready_q;
  assign cc_valid = (state_q == ST_CC_SEND);
  assign unused_in = ^{s_axis_cq_tkeep, s_axis_cq_tuser, s_axis_cq_tdata};

  pcie_us_be_decode u_be_decode (
    .first_be   (first_be_q),
    .byte_count (be_byte_count),
    .low_offset (be_low_offset)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    first_be_d = first_be_q;
    req_id_d   = req_id_q;
    tag_d      = tag_q;
    tc_d       = tc_q;
    attr_d     = attr_q;
    data_d     = data_q;
    last_d     = last_q;
    ur_d       = ur_q;
    err_d      = 1'b0;
    tmr_d      = tmr_q;

    case (state_q)
      ST_IDLE: begin
        if (cq_hs) begin
          addr_d     = s_axis_cq_tdata[ADDR_KEEP_W-1:2];
          first_be_d = s_axis_cq_tuser[3:0];
          req_id_d   = s_axis_cq_tdata[CQ_REQID_LSB +: 16];
          tag_d      = s_axis_cq_tdata[CQ_TAG_LSB +: 8];
          tc_d       = s_axis_cq_tdata[CQ_TC_LSB +: 3];
          attr_d     = s_axis_cq_tdata[CQ_ATTR_LSB +: 3];
          data_d     = s_axis_cq_tdata[CQ_DATA_LSB +: 32];
          last_d     = s_axis_cq_tlast;
          ur_d       = 1'b0;
          if (req_type == REQ_MEM_WR && req_dw_cnt == 11'd1) begin
            state_d = ST_WRITE;
          end else if (req_type == REQ_MEM_RD && req_dw_cnt == 11'd1) begin
            state_d = ST_READ;
          end else if (req_non_posted) begin
            ur_d    = 1'b1;
            err_d   = 1'b1;
            state_d = ST_CC_SEND;
          end else begin
            err_d   = 1'b1;
            state_d = s_axis_cq_tlast ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_WRITE: state_d = last_q ? ST_IDLE : ST_DROP;
      ST_READ: begin
        tmr_d = '0;
        if (reg_rd_ack) begin
          data_d  = reg_rd_data;
          state_d = ST_CC_SEND;
        end else begin
          state_d = ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: begin
        // A real ack wins over a timeout landing in the same cycle.
        if (reg_rd_ack) begin
          data_d  = reg_rd_data;
          state_d = ST_CC_SEND;
        end else if (tmr_q == TMR_W'(RD_TIMEOUT)) begin
          data_d  = '1;
          state_d = ST_CC_SEND;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_CC_SEND: begin
        if (m_axis_cc_tready) state_d = last_q ? ST_IDLE : ST_DROP;
      end
      ST_DROP: begin
        if (cq_hs && s_axis_cq_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cq_tready_d = (state_d == ST_IDLE) || (state_d == ST_DROP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cq_tready_q <= 1'b0;
      addr_q      <= '0;
      first_be_q  <= '0;
      req_id_q    <= '0;
      tag_q       <= '0;
      tc_q        <= '0;
      attr_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      ur_q        <= 1'b0;
      err_q       <= 1'b0;
      tmr_q       <= '0;
    end else begin
      state_q     <= state_d;
      cq_tready_q <= cq_tready_d;
      addr_q      <= addr_d;
      first_be_q  <= first_be_d;
      req_id_q    <= req_id_d;
      tag_q       <= tag_d;
      tc_q        <= tc_d;
      attr_q      <= attr_d;
      data_q      <= data_d;
      last_q      <= last_d;
      ur_q        <= ur_d;
      err_q       <= err_d;
      tmr_q       <= tmr_d;
    end
  end

  always_comb begin
    m_axis_cc_tdata = '0;
    m_axis_cc_tkeep = '0;
    if (cc_valid) begin
      if (ur_q) begin
        m_axis_cc_tdata[CC_BYTECNT_LSB +: 13] = 13'd4;
        m_axis_cc_tdata[CC_STATUS_LSB +: 3]   = CPL_UR;
        m_axis_cc_tkeep[2:0]                  = 3'b111;
      end else begin
        m_axis_cc_tdata[CC_LOWADDR_LSB +: 7]  = {addr_q[6:2], be_low_offset};
        m_axis_cc_tdata[CC_BYTECNT_LSB +: 13] = {10'd0, be_byte_count};
        m_axis_cc_tdata[CC_DWCNT_LSB +: 11]   = 11'd1;
        m_axis_cc_tdata[CC_STATUS_LSB +: 3]   = CPL_SC;
        m_axis_cc_tdata[CC_DATA_LSB +: 32]    = data_q;
        m_axis_cc_tkeep[3:0]                  = 4'b1111;
      end
      m_axis_cc_tdata[CC_REQID_LSB +: 16]  = req_id_q;
      m_axis_cc_tdata[CC_TAG_LSB +: 8]     = tag_q;
      m_axis_cc_tdata[CC_CPLID_LSB +: 16]  = completer_id;
      m_axis_cc_tdata[CC_CPLID_EN_BIT]     = 1'b0;
      m_axis_cc_tdata[CC_TC_LSB +: 3]      = tc_q;
      m_axis_cc_tdata[CC_ATTR_LSB +: 3]    = attr_q;
    end
  end

  assign m_axis_cc_tvalid   = cc_valid;
  assign m_axis_cc_tlast    = cc_valid;
  assign m_axis_cc_tuser    = '0;
  assign s_axis_cq_tready   = cq_tready_q;
  assign reg_wr_en          = (state_q == ST_WRITE);
  assign reg_wr_addr        = {addr_q[REG_ADDR_WIDTH-1:2], 2'b00};
  assign reg_wr_data        = data_q;
  assign reg_wr_strb        = first_be_q;
  assign reg_rd_en          = (state_q == ST_READ);
  assign reg_rd_addr        = {addr_q[REG_ADDR_WIDTH-1:2], 2'b00};
  assign status_error_uncor = err_q;

endmodule

// File: tb/tb_pcie_us_cq_reg_target.sv
// Directed bench for pcie_us_cq_reg_target: writes, reads, UR, read timeout,
// CC backpressure and multi-beat message draining.
module tb_pcie_us_cq_reg_target;

  localparam int DW  = 256;
  localparam int KW  = 8;
  localparam int CQU = 85;
  localparam int CCU = 33;
  localparam int RAW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  s_axis_cq_tdata = '0;
  logic [KW-1:0]  s_axis_cq_tkeep = '0;
  logic           s_axis_cq_tvalid = 1'b0;
  logic           s_axis_cq_tready;
  logic           s_axis_cq_tlast = 1'b0;
  logic [CQU-1:0] s_axis_cq_tuser = '0;
  logic [DW-1:0]  m_axis_cc_tdata;
  logic [KW-1:0]  m_axis_cc_tkeep;
  logic           m_axis_cc_tvalid;
  logic           m_axis_cc_tready = 1'b1;
  logic           m_axis_cc_tlast;
  logic [CCU-1:0] m_axis_cc_tuser;
  logic [15:0]    completer_id = 16'h0A10;
  logic [RAW-1:0] reg_wr_addr;
  logic [31:0]    reg_wr_data;
  logic [3:0]     reg_wr_strb;
  logic           reg_wr_en;
  logic [RAW-1:0] reg_rd_addr;
  logic           reg_rd_en;
  logic [31:0]    reg_rd_data = '0;
  logic           reg_rd_ack = 1'b0;
  logic           status_error_uncor;

  always #5 clk = ~clk;

  pcie_us_cq_reg_target #(
    .AXIS_PCIE_DATA_WIDTH    (DW),
    .AXIS_PCIE_KEEP_WIDTH    (KW),
    .AXIS_PCIE_CQ_USER_WIDTH (CQU),
    .AXIS_PCIE_CC_USER_WIDTH (CCU),
    .REG_ADDR_WIDTH          (RAW),
    .RD_TIMEOUT              (255)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_cq_tdata    (s_axis_cq_tdata),
    .s_axis_cq_tkeep    (s_axis_cq_tkeep),
    .s_axis_cq_tvalid   (s_axis_cq_tvalid),
    .s_axis_cq_tready   (s_axis_cq_tready),
    .s_axis_cq_tlast    (s_axis_cq_tlast),
    .s_axis_cq_tuser    (s_axis_cq_tuser),
    .m_axis_cc_tdata    (m_axis_cc_tdata),
    .m_axis_cc_tkeep    (m_axis_cc_tkeep),
    .m_axis_cc_tvalid   (m_axis_cc_tvalid),
    .m_axis_cc_tready   (m_axis_cc_tready),
    .m_axis_cc_tlast    (m_axis_cc_tlast),
    .m_axis_cc_tuser    (m_axis_cc_tuser),
    .completer_id       (completer_id),
    .reg_wr_addr        (reg_wr_addr),
    .reg_wr_data        (reg_wr_data),
    .reg_wr_strb        (reg_wr_strb),
    .reg_wr_en          (reg_wr_en),
    .reg_rd_addr        (reg_rd_addr),
    .reg_rd_en          (reg_rd_en),
    .reg_rd_data        (reg_rd_data),
    .reg_rd_ack         (reg_rd_ack),
    .status_error_uncor (status_error_uncor)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Event monitor (negedge): counts strobes/pulses/handshakes and keeps the last values.
  int             wr_cnt = 0, rd_cnt = 0, err_cnt = 0, cc_cnt = 0;
  logic [RAW-1:0] wr_addr_s = '0, rd_addr_s = '0;
  logic [31:0]    wr_data_s = '0;
  logic [3:0]     wr_strb_s = '0;
  logic [DW-1:0]  cc_data_s = '0;
  logic [KW-1:0]  cc_keep_s = '0;
  logic           cc_last_s = 1'b0;
  logic [CCU-1:0] cc_user_s = '0;
  int             cc_cyc = 0, acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_cnt++;
      wr_addr_s = reg_wr_addr;
      wr_data_s = reg_wr_data;
      wr_strb_s = reg_wr_strb;
    end
    if (reg_rd_en) begin
      rd_cnt++;
      rd_addr_s = reg_rd_addr;
    end
    if (status_error_uncor) err_cnt++;
    if (m_axis_cc_tvalid && m_axis_cc_tready) begin
      cc_cnt++;
      cc_data_s = m_axis_cc_tdata;
      cc_keep_s = m_axis_cc_tkeep;
      cc_last_s = m_axis_cc_tlast;
      cc_user_s = m_axis_cc_tuser;
      cc_cyc    = cyc;
    end
    if (s_axis_cq_tvalid && s_axis_cq_tready) acc_cyc = cyc;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Requester ID 0xBEEF, TC 5, attr 2 on every request.
  function automatic logic [DW-1:0] mk_desc(input logic [3:0] rt, input logic [10:0] dc,
                                            input logic [63:0] addr, input logic [7:0] tag,
                                            input logic [31:0] data);
    logic [DW-1:0] d;
    d          = '0;
    d[63:2]    = addr[63:2];
    d[74:64]   = dc;
    d[78:75]   = rt;
    d[95:80]   = 16'hBEEF;
    d[103:96]  = tag;
    d[123:121] = 3'd5;
    d[126:124] = 3'd2;
    d[159:128] = data;
    return d;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic [3:0] be, input logic last);
    int n;
    s_axis_cq_tdata      = d;
    s_axis_cq_tuser      = '0;
    s_axis_cq_tuser[3:0] = be;
    s_axis_cq_tkeep      = '1;
    s_axis_cq_tlast      = last;
    s_axis_cq_tvalid     = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axis_cq_tready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("cq_accept_timeout", 64'(s_axis_cq_tready), 64'd1);
    @(posedge clk); #1;
    s_axis_cq_tvalid = 1'b0;
    s_axis_cq_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cc(input int base, input int limit, input string tag);
    int n;
    n = 0;
    while (cc_cnt == base && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(cc_cnt - base), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rd_en(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (!reg_rd_en && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("rd_en_seen", 64'(reg_rd_en), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang, expected completion");
    $fatal(1);
  end

  initial begin
    int wr0, rd0, err0, cc0, n;
    logic [DW-1:0] cd, snap;
    logic stable, accepted;

    // Reset state
    idle(3);
    check("rst_cq_tready", 64'(s_axis_cq_tready), 64'd0);
    check("rst_cc_tvalid", 64'(m_axis_cc_tvalid), 64'd0);
    check("rst_wr_en", 64'(reg_wr_en), 64'd0);
    check("rst_rd_en", 64'(reg_rd_en), 64'd0);
    check("rst_err", 64'(status_error_uncor), 64'd0);
    check("rst_wr_addr", 64'(reg_wr_addr), 64'd0);
    rst = 1'b0;
    idle(2);
    check("idle_cq_tready", 64'(s_axis_cq_tready), 64'd1);

    // 1-DW write
    wr0 = wr_cnt; cc0 = cc_cnt; err0 = err_cnt;
    send_beat(mk_desc(4'b0001, 11'd1, 64'h10, 8'h11, 32'hA5A5_1234), 4'b1111, 1'b1);
    idle(6);
    check("wr_pulses", 64'(wr_cnt - wr0), 64'd1);
    check("wr_addr", 64'(wr_addr_s), 64'h0010);
    check("wr_data", 64'(wr_data_s), 64'hA5A5_1234);
    check("wr_strb", 64'(wr_strb_s), 64'hF);
    check("wr_no_cc", 64'(cc_cnt - cc0), 64'd0);
    check("wr_no_err", 64'(err_cnt - err0), 64'd0);

    // 1-DW read, ack two cycles after the strobe
    rd0 = rd_cnt; cc0 = cc_cnt;
    send_beat(mk_desc(4'b0000, 11'd1, 64'h24, 8'h3C, 32'h0), 4'b0110, 1'b1);
    wait_rd_en(20);
    idle(1);
    idle(1);
    reg_rd_data = 32'hCAFE_F00D;
    reg_rd_ack  = 1'b1;
    idle(1);
    reg_rd_ack  = 1'b0;
    wait_cc(cc0, 50, "rd_cc_arrived");
    cd = cc_data_s;
    check("rd_strobes", 64'(rd_cnt - rd0), 64'd1);
    check("rd_addr", 64'(rd_addr_s), 64'h0024);
    check("rd_lower_addr", 64'(cd[6:0]), 64'h25);
    check("rd_byte_count", 64'(cd[28:16]), 64'd2);
    check("rd_dw_count", 64'(cd[42:32]), 64'd1);
    check("rd_status", 64'(cd[45:43]), 64'd0);
    check("rd_req_id", 64'(cd[63:48]), 64'hBEEF);
    check("rd_tag", 64'(cd[71:64]), 64'h3C);
    check("rd_cpl_id", 64'(cd[87:72]), 64'h0A10);
    check("rd_cpl_id_en", 64'(cd[88]), 64'd0);
    check("rd_tc", 64'(cd[91:89]), 64'd5);
    check("rd_attr", 64'(cd[94:92]), 64'd2);
    check("rd_data", 64'(cd[127:96]), 64'hCAFE_F00D);
    check("rd_keep", 64'(cc_keep_s), 64'h0F);
    check("rd_last", 64'(cc_last_s), 64'd1);
    check("rd_user", 64'(cc_user_s), 64'd0);

    // Multi-DW read: unsupported request
    rd0 = rd_cnt; cc0 = cc_cnt; err0 = err_cnt;
    send_beat(mk_desc(4'b0000, 11'd4, 64'h40, 8'h07, 32'h0), 4'b1111, 1'b1);
    wait_cc(cc0, 50, "ur_cc_arrived");
    idle(2);
    cd = cc_data_s;
    check("ur_no_rd_en", 64'(rd_cnt - rd0), 64'd0);
    check("ur_status", 64'(cd[45:43]), 64'd1);
    check("ur_keep", 64'(cc_keep_s), 64'h07);
    check("ur_tag", 64'(cd[71:64]), 64'h07);
    check("ur_byte_count", 64'(cd[28:16]), 64'd4);
    check("ur_dw_count", 64'(cd[42:32]), 64'd0);
    check("ur_lower_addr", 64'(cd[6:0]), 64'd0);
    check("ur_err_pulses", 64'(err_cnt - err0), 64'd1);

    // Read with no ack: timeout completion
    cc0 = cc_cnt;
    send_beat(mk_desc(4'b0000, 11'd1, 64'h30, 8'h21, 32'h0), 4'b1111, 1'b1);
    wait_cc(cc0, 400, "to_cc_arrived");
    cd = cc_data_s;
    check("to_data", 64'(cd[127:96]), 64'hFFFF_FFFF);
    check("to_status", 64'(cd[45:43]), 64'd0);
    check("to_latency_window", 64'((cc_cyc - acc_cyc) >= 256 && (cc_cyc - acc_cyc) <= 260), 64'd1);
    reg_rd_data = 32'h1111_1111;
    reg_rd_ack  = 1'b1;
    idle(1);
    reg_rd_ack  = 1'b0;
    idle(5);
    check("late_ack_no_cc", 64'(cc_cnt - cc0), 64'd1);
    check("late_ack_idle", 64'(s_axis_cq_tready), 64'd1);

    // Completion backpressure, ack in the same cycle as the read strobe
    m_axis_cc_tready = 1'b0;
    cc0 = cc_cnt; wr0 = wr_cnt;
    send_beat(mk_desc(4'b0000, 11'd1, 64'h08, 8'h55, 32'h0), 4'b1111, 1'b1);
    wait_rd_en(20);
    reg_rd_data = 32'h1234_5678;
    reg_rd_ack  = 1'b1;
    @(posedge clk); #1;
    reg_rd_ack  = 1'b0;
    n = 0;
    @(negedge clk);
    while (!m_axis_cc_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_cc_valid", 64'(m_axis_cc_tvalid), 64'd1);
    snap = m_axis_cc_tdata;
    s_axis_cq_tdata      = mk_desc(4'b0001, 11'd1, 64'h40, 8'h00, 32'hDEAD_0040);
    s_axis_cq_tuser      = '0;
    s_axis_cq_tuser[3:0] = 4'b1111;
    s_axis_cq_tlast      = 1'b1;
    s_axis_cq_tvalid     = 1'b1;
    stable = 1'b1;
    accepted = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (m_axis_cc_tdata !== snap || !m_axis_cc_tvalid) stable = 1'b0;
      if (s_axis_cq_tready) accepted = 1'b1;
    end
    check("bp_cc_stable", 64'(stable), 64'd1);
    check("bp_no_cq_accept", 64'(accepted), 64'd0);
    check("bp_no_handshake", 64'(cc_cnt - cc0), 64'd0);
    @(posedge clk); #1;
    m_axis_cc_tready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axis_cq_tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_cq_ready_after", 64'(s_axis_cq_tready), 64'd1);
    @(posedge clk); #1;
    s_axis_cq_tvalid = 1'b0;
    s_axis_cq_tlast  = 1'b0;
    idle(5);
    cd = cc_data_s;
    check("bp_handshakes", 64'(cc_cnt - cc0), 64'd1);
    check("bp_data", 64'(cd[127:96]), 64'h1234_5678);
    check("bp_byte_count", 64'(cd[28:16]), 64'd4);
    check("bp_lower_addr", 64'(cd[6:0]), 64'h08);
    check("bp_tag", 64'(cd[71:64]), 64'h55);
    check("bp_next_wr", 64'(wr_cnt - wr0), 64'd1);
    check("bp_next_wr_addr", 64'(wr_addr_s), 64'h0040);
    check("bp_next_wr_data", 64'(wr_data_s), 64'hDEAD_0040);

    // Three-beat message: drained and flagged
    wr0 = wr_cnt; rd0 = rd_cnt; cc0 = cc_cnt; err0 = err_cnt;
    send_beat(mk_desc(4'b1100, 11'd2, 64'h0, 8'h66, 32'h0), 4'b0000, 1'b0);
    send_beat({8{32'h5A5A_0001}}, 4'b0000, 1'b0);
    send_beat({8{32'h5A5A_0002}}, 4'b0000, 1'b1);
    idle(5);
    check("msg_err_pulses", 64'(err_cnt - err0), 64'd1);
    check("msg_no_wr", 64'(wr_cnt - wr0), 64'd0);
    check("msg_no_rd", 64'(rd_cnt - rd0), 64'd0);
    check("msg_no_cc", 64'(cc_cnt - cc0), 64'd0);
    check("msg_back_idle", 64'(s_axis_cq_tready), 64'd1);

    // Write with no byte enables still strobes
    wr0 = wr_cnt;
    send_beat(mk_desc(4'b0001, 11'd1, 64'h1FC, 8'h01, 32'h0BAD_F00D), 4'b0000, 1'b1);
    idle(4);
    check("wr0be_pulses", 64'(wr_cnt - wr0), 64'd1);
    check("wr0be_strb", 64'(wr_strb_s), 64'h0);
    check("wr0be_addr", 64'(wr_addr_s), 64'h01FC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
